// File: rtl/lut_loader_pkg.sv
// Shared types and constants for the LUT loader: FSM state encoding and checksum width.
package lut_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned CHECKSUM_W = 16;

endpackage

// File: rtl/lut_loader_ram.sv
// Table storage for lut_loader: one synchronous write port, one asynchronous read port, no reset.
module lut_ram #(
   parameter  int unsigned WIDTH  = 8,
   parameter  int unsigned DEPTH  = 256,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_sig,
   input  logic              we_sig,
   input  logic [ADDR_W-1:0] wr_addr_sig,
   input  logic [WIDTH-1:0]  wr_data_sig,
   input  logic [ADDR_W-1:0] addr_sig,
   output logic [WIDTH-1:0]  q_sig
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_sig) begin
      if (we_sig) mem[wr_addr_sig] <= wr_data_sig;
   end

   // Same-cycle read of the entry being written sees the old content.
   assign q_sig = mem[addr_sig];

endmodule

// File: rtl/lut_loader.sv
// Streams a full table of samples into lut_ram after a start pulse.
// Optional running checksum of accepted samples: define LUT_LOADER_CHECKSUM_EN.
module lut_loader
   import lut_loader_pkg::*;
#(
   parameter  int unsigned WIDTH  = 8,
   parameter  int unsigned DEPTH  = 256,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                  clk_sig,
   input  logic                  rst_n_sig,
   input  logic                  start_sig,
   input  logic [WIDTH-1:0]      s_data_sig,
   input  logic                  s_valid_sig,
   output logic                  s_ready_sig,
   output logic                  busy_sig,
   output logic                  done_sig,
   input  logic [ADDR_W-1:0]     rd_addr_sig,
   output logic [WIDTH-1:0]      rd_q_sig,
   output logic [CHECKSUM_W-1:0] checksum_sig
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] wr_addr;
   logic              accept;

   // A start pulse always wins over a same-cycle beat.
   assign s_ready_sig = (state == LOAD) && !start_sig;
   assign accept      = s_valid_sig && s_ready_sig;

   always_ff @(posedge clk_sig or negedge rst_n_sig) begin
      if (!rst_n_sig) begin
         state    <= IDLE;
         wr_addr  <= '0;
         busy_sig <= 1'b0;
         done_sig <= 1'b0;
      end else if (start_sig) begin
         state    <= LOAD;
         wr_addr  <= '0;
         busy_sig <= 1'b1;
         done_sig <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (accept) begin
                  if (wr_addr == LAST_ADDR) begin
                     state    <= DONE;
                     busy_sig <= 1'b0;
                     done_sig <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr + 1'b1;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               done_sig <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               busy_sig <= 1'b0;
               done_sig <= 1'b0;
            end
         endcase
      end
   end

`ifdef LUT_LOADER_CHECKSUM_EN
   logic [CHECKSUM_W-1:0] checksum;

   always_ff @(posedge clk_sig or negedge rst_n_sig) begin
      if (!rst_n_sig)  checksum <= '0;
      else if (start_sig) checksum <= '0;
      else if (accept) checksum <= checksum + CHECKSUM_W'(s_data_sig);
   end

   assign checksum_sig = checksum;
`else
   assign checksum_sig = '0;
`endif

   lut_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_sig     (clk_sig),
      .we_sig      (accept),
      .wr_addr_sig (wr_addr),
      .wr_data_sig (s_data_sig),
      .addr_sig    (rd_addr_sig),
      .q_sig       (rd_q_sig)
   );

endmodule

// File: tb/tb_lut_loader.sv
// Scoreboard bench for lut_loader (DEPTH=8): stimulus queues expectations, negedge monitors compare.
module tb_lut_loader;
   import lut_loader_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 8;

`ifdef LUT_LOADER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic                  clk_sig = 1'b0;
   logic                  rst_n_sig = 1'b0;
   logic                  start_sig = 1'b0;
   logic [WIDTH-1:0]      s_data_sig = '0;
   logic                  s_valid_sig = 1'b0;
   logic                  s_ready_sig;
   logic                  busy_sig;
   logic                  done_sig;
   logic [2:0]            rd_addr_sig = '0;
   logic [WIDTH-1:0]      rd_q_sig;
   logic [CHECKSUM_W-1:0] checksum_sig;

   lut_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_sig      (clk_sig),
      .rst_n_sig    (rst_n_sig),
      .start_sig    (start_sig),
      .s_data_sig   (s_data_sig),
      .s_valid_sig  (s_valid_sig),
      .s_ready_sig  (s_ready_sig),
      .busy_sig     (busy_sig),
      .done_sig     (done_sig),
      .rd_addr_sig  (rd_addr_sig),
      .rd_q_sig     (rd_q_sig),
      .checksum_sig (checksum_sig)
   );

   always #5 clk_sig = ~clk_sig;

   int cyc = 0;
   always @(posedge clk_sig) cyc <= cyc + 1;

   // kind: 0 = table read, 1 = checksum, 2 = s_ready level
   typedef struct {
      int kind;
      int exp;
   } probe_t;

   int     exp_acc[$];
   int     exp_done[$];
   int     exp_busy[$];
   probe_t exp_probe[$];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- monitors ----------------
   int busy_run = 0;

   always @(negedge clk_sig) begin
      if (s_valid_sig && s_ready_sig) begin
         if (exp_acc.size() == 0) chk("unexpected_accept", int'(s_data_sig), -1);
         else chk("accept_data", int'(s_data_sig), exp_acc.pop_front());
      end
      if (done_sig) begin
         if (exp_done.size() == 0) chk("unexpected_done", cyc, -1);
         else chk("done_cycle", cyc, exp_done.pop_front());
      end
      if (busy_sig) begin
         busy_run++;
      end else if (busy_run > 0) begin
         if (exp_busy.size() == 0) chk("unexpected_busy_run", busy_run, -1);
         else chk("busy_len", busy_run, exp_busy.pop_front());
         busy_run = 0;
      end
      while (exp_probe.size() > 0) begin
         probe_t p;
         p = exp_probe.pop_front();
         case (p.kind)
            0:       chk($sformatf("rd[%0d]", rd_addr_sig), int'(rd_q_sig), p.exp);
            1:       chk("checksum", int'(checksum_sig), p.exp);
            default: chk("s_ready", int'(s_ready_sig), p.exp);
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk_sig);
      #1;
   endtask

   task automatic do_start();
      start_sig = 1'b1;
      step();
      start_sig = 1'b0;
   endtask

   task automatic probe_rd(input int addr, input int exp);
      probe_t p;
      rd_addr_sig = 3'(addr);
      p.kind = 0;
      p.exp  = exp;
      exp_probe.push_back(p);
      step();
   endtask

   task automatic probe_other(input int kind, input int exp);
      probe_t p;
      p.kind = kind;
      p.exp  = exp;
      exp_probe.push_back(p);
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},     int'(busy_sig),     0);
      chk({tag, "_done"},     int'(done_sig),     0);
      chk({tag, "_s_ready"},  int'(s_ready_sig),  0);
      chk({tag, "_checksum"}, int'(checksum_sig), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 10000", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      #1;
      check_reset_outputs("por");
      step();
      rst_n_sig = 1'b1;
      step();

      // Back-to-back full load 0x10..0x17
      exp_busy.push_back(8);
      do_start();
      for (int i = 0; i < 8; i++) begin
         s_valid_sig = 1'b1;
         s_data_sig  = 8'(8'h10 + i);
         exp_acc.push_back(16 + i);
         if (i == 7) exp_done.push_back(cyc + 1);
         step();
      end
      s_valid_sig = 1'b0;
      step();
      for (int i = 0; i < 8; i++) probe_rd(i, 16 + i);
      probe_other(1, CSUM_ON ? 16'h009C : 0);

      // Valid toggling every cycle: 8 accepted beats over 15 cycles
      exp_busy.push_back(15);
      do_start();
      for (int i = 0; i < 15; i++) begin
         s_valid_sig = (i % 2 == 0);
         s_data_sig  = 8'(8'h20 + i / 2);
         if (i % 2 == 0) exp_acc.push_back(32 + i / 2);
         if (i == 14) exp_done.push_back(cyc + 1);
         step();
      end
      s_valid_sig = 1'b0;
      step();
      for (int i = 0; i < 8; i++) probe_rd(i, 32 + i);

      // Restart mid-load: the 0xFF beat coincides with start and must be dropped
      exp_busy.push_back(5);
      do_start();
      for (int i = 0; i < 3; i++) begin
         s_valid_sig = 1'b1;
         s_data_sig  = 8'(8'hA0 + i);
         exp_acc.push_back(160 + i);
         step();
      end
      start_sig   = 1'b1;
      s_data_sig  = 8'hFF;
      probe_other(2, 0);
      start_sig   = 1'b0;
      s_data_sig  = 8'hB0;
      exp_acc.push_back(8'hB0);
      step();
      s_valid_sig = 1'b0;
      rst_n_sig   = 1'b0;
      step();
      rst_n_sig   = 1'b1;
      step();
      probe_rd(0, 8'hB0);
      probe_rd(1, 8'hA1);
      probe_rd(2, 8'hA2);
      probe_rd(3, 8'h23);

      // Reset mid-load after 4 beats of 0x55
      exp_busy.push_back(4);
      do_start();
      for (int i = 0; i < 4; i++) begin
         s_valid_sig = 1'b1;
         s_data_sig  = 8'h55;
         exp_acc.push_back(8'h55);
         step();
      end
      s_data_sig = 8'h99;
      rst_n_sig  = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      step();
      step();
      rst_n_sig = 1'b1;
      for (int i = 0; i < 4; i++) step();
      s_valid_sig = 1'b0;
      for (int i = 0; i < 4; i++) probe_rd(i, 8'h55);
      probe_rd(4, 8'h24);

      // All-0xFF load for the checksum
      exp_busy.push_back(8);
      do_start();
      for (int i = 0; i < 8; i++) begin
         s_valid_sig = 1'b1;
         s_data_sig  = 8'hFF;
         exp_acc.push_back(8'hFF);
         if (i == 7) exp_done.push_back(cyc + 1);
         step();
      end
      s_valid_sig = 1'b0;
      step();
      probe_other(1, CSUM_ON ? 16'h07F8 : 0);

      // Valid in IDLE is ignored
      s_valid_sig = 1'b1;
      s_data_sig  = 8'h3C;
      for (int i = 0; i < 5; i++) probe_other(2, 0);
      s_valid_sig = 1'b0;
      for (int i = 0; i < 8; i++) probe_rd(i, 8'hFF);

      step();
      step();
      chk("acc_queue_left",  exp_acc.size(),  0);
      chk("done_queue_left", exp_done.size(), 0);
      chk("busy_queue_left", exp_busy.size(), 0);
      chk("busy_run_open",   busy_run,        0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
